// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 single-wire pixel serializer with latch gap and pixel/frame strobes
// Pulls 24-bit GRB words over valid/ready and emits MSB-first pulse-width-coded bits.
module ws2812_tx #(
    parameter int T0H_CYCLES    = 40,
    parameter int T0L_CYCLES    = 85,
    parameter int T1H_CYCLES    = 80,
    parameter int T1L_CYCLES    = 45,
    parameter int TRESET_CYCLES = 8000,
    parameter int NUM_PIXELS    = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [23:0] pixel_data_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    output logic        pixel_done_out,
    output logic        frame_done_out,
    output logic        busy_out,
    output logic        strip_out
);

    localparam int TMAX_A = (T0H_CYCLES > T0L_CYCLES) ? T0H_CYCLES : T0L_CYCLES;
    localparam int TMAX_B = (T1H_CYCLES > T1L_CYCLES) ? T1H_CYCLES : T1L_CYCLES;
    localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMAX   = (TMAX_C > TRESET_CYCLES) ? TMAX_C : TRESET_CYCLES;
    localparam int TW     = $clog2(TMAX) + 1;
    localparam int PW     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS + 1) : 1;

    localparam logic [TW-1:0] T0H_M1    = TW'(T0H_CYCLES - 1);
    localparam logic [TW-1:0] T0L_M1    = TW'(T0L_CYCLES - 1);
    localparam logic [TW-1:0] T1H_M1    = TW'(T1H_CYCLES - 1);
    localparam logic [TW-1:0] T1L_M1    = TW'(T1L_CYCLES - 1);
    localparam logic [TW-1:0] TRESET_M1 = TW'(TRESET_CYCLES - 1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(NUM_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bit_idx_q, bit_idx_d;
    logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
    logic            pixel_done_q, pixel_done_d;
    logic            strip_q;
    logic            frame_done;

    function automatic logic [TW-1:0] high_len_m1(input logic b);
        return b ? T1H_M1 : T0H_M1;
    endfunction

    function automatic logic [TW-1:0] low_len_m1(input logic b);
        return b ? T1L_M1 : T0L_M1;
    endfunction

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        shift_d         = shift_q;
        bit_idx_d       = bit_idx_q;
        pix_cnt_d       = pix_cnt_q;
        pixel_done_d    = 1'b0;
        frame_done      = 1'b0;
        pixel_ready_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pixel_ready_out = 1'b1;
                if (pixel_valid_in) begin
                    shift_d   = pixel_data_in;
                    bit_idx_d = 5'd23;
                    cnt_d     = high_len_m1(pixel_data_in[23]);
                    state_d   = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d   = low_len_m1(shift_q[23]);
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (bit_idx_q != 5'd0) begin
                    shift_d   = {shift_q[22:0], 1'b0};
                    bit_idx_d = bit_idx_q - 5'd1;
                    cnt_d     = high_len_m1(shift_q[22]);
                    state_d   = S_HIGH;
                end else begin
                    pixel_done_d = 1'b1;
                    // The final pixel holds its count; it clears when the latch gap ends.
                    if (pix_cnt_q == LAST_PIX) begin
                        cnt_d   = TRESET_M1;
                        state_d = S_LATCH;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    frame_done = 1'b1;
                    pix_cnt_d  = '0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            pix_cnt_q    <= '0;
            pixel_done_q <= 1'b0;
            strip_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            pixel_done_q <= pixel_done_d;
            strip_q      <= (state_d == S_HIGH);
        end
    end

    assign pixel_done_out = pixel_done_q;
    assign frame_done_out = frame_done;
    assign busy_out       = (state_q != S_IDLE);
    assign strip_out      = strip_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - directed bench for ws2812_tx with small timing parameters
// A second instance with NUM_PIXELS=1 covers the single-pixel frame.
`timescale 1ns/1ps
module tb_ws2812_tx;

    localparam int T0H = 2;
    localparam int T0L = 4;
    localparam int T1H = 4;
    localparam int T1L = 2;
    localparam int TR  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [23:0] data = 24'h0;
    logic        valid = 1'b0;
    logic        sel = 1'b0;

    logic ready0, pd0, fd0, busy0, strip0;
    logic ready1, pd1, fd1, busy1, strip1;
    logic m_ready, m_pd, m_fd, m_busy, m_strip;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int pd_cnt = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    ws2812_tx #(.T0H_CYCLES(T0H), .T0L_CYCLES(T0L), .T1H_CYCLES(T1H), .T1L_CYCLES(T1L),
                .TRESET_CYCLES(TR), .NUM_PIXELS(2)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start0),
        .pixel_data_in(data), .pixel_valid_in(valid),
        .pixel_ready_out(ready0), .pixel_done_out(pd0), .frame_done_out(fd0),
        .busy_out(busy0), .strip_out(strip0)
    );

    ws2812_tx #(.T0H_CYCLES(T0H), .T0L_CYCLES(T0L), .T1H_CYCLES(T1H), .T1L_CYCLES(T1L),
                .TRESET_CYCLES(TR), .NUM_PIXELS(1)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start1),
        .pixel_data_in(data), .pixel_valid_in(valid),
        .pixel_ready_out(ready1), .pixel_done_out(pd1), .frame_done_out(fd1),
        .busy_out(busy1), .strip_out(strip1)
    );

    assign m_ready = sel ? ready1 : ready0;
    assign m_pd    = sel ? pd1    : pd0;
    assign m_fd    = sel ? fd1    : fd0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_strip = sel ? strip1 : strip0;

    always @(negedge clk) begin
        #1;
        if (valid && m_ready) hs_cnt++;
        if (m_pd) pd_cnt++;
        if (m_fd) fd_cnt++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else start0 = v;
    endtask

    task automatic begin_frame(input string name);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        checks++;
        if (m_ready !== 1'b1 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s load: ready=%b busy=%b, want ready=1 busy=1", name, m_ready, m_busy);
        end
        tick();
    endtask

    // Entered on the first high cycle; leaves on the cycle after the last low cycle.
    task automatic check_pixel(input logic [23:0] w, input int poke, input string name);
        int c, bad, bad_b, bad_c, pd_bad, h, l;
        logic got, exp;
        c = 0; bad = 0; bad_b = 0; bad_c = 0; pd_bad = 0; got = 1'b0; exp = 1'b0;
        for (int b = 23; b >= 0; b--) begin
            h = w[b] ? T1H : T0H;
            l = w[b] ? T1L : T0L;
            for (int k = 0; k < h + l; k++) begin
                if (m_strip !== (k < h) && bad == 0) begin
                    bad = 1; bad_b = b; bad_c = c; got = m_strip; exp = (k < h);
                end
                if (m_pd !== 1'b0) pd_bad = 1;
                if (c == poke) set_start(1'b1);
                else if (c == poke + 1) set_start(1'b0);
                c++;
                tick();
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s strip bit %0d cycle %0d: got %b want %b", name, bad_b, bad_c, got, exp);
        end
        checks++;
        if (pd_bad != 0) begin
            errors++;
            $display("FAIL %s early pixel_done: got 1 want 0 within %0d cycles", name, c);
        end
        checks++;
        if (m_pd !== 1'b1) begin
            errors++;
            $display("FAIL %s pixel_done at cycle %0d: got %b want 1", name, c, m_pd);
        end
    endtask

    // Entered on the first latch cycle; leaves on the first idle cycle.
    task automatic run_latch(input int poke, input string name);
        int s_bad, f_bad;
        s_bad = 0; f_bad = 0;
        for (int i = 1; i <= TR; i++) begin
            if (m_strip !== 1'b0) s_bad++;
            if (m_fd !== (i == TR)) f_bad++;
            if (i == poke) set_start(1'b1);
            else set_start(1'b0);
            tick();
        end
        set_start(1'b0);
        checks++;
        if (s_bad != 0) begin
            errors++;
            $display("FAIL %s latch strip: got %0d high cycles want 0", name, s_bad);
        end
        checks++;
        if (f_bad != 0) begin
            errors++;
            $display("FAIL %s latch frame_done: %0d wrong cycles want 0", name, f_bad);
        end
        checks++;
        if (m_busy !== 1'b0 || m_fd !== 1'b0) begin
            errors++;
            $display("FAIL %s after latch: busy=%b fd=%b want 0 0", name, m_busy, m_fd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({strip0, busy0, ready0, pd0, fd0} !== 5'b0) begin
            errors++;
            $display("FAIL reset dut0 outputs: got %b want 00000", {strip0, busy0, ready0, pd0, fd0});
        end
        checks++;
        if ({strip1, busy1, ready1, pd1, fd1} !== 5'b0) begin
            errors++;
            $display("FAIL reset dut1 outputs: got %b want 00000", {strip1, busy1, ready1, pd1, fd1});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy0 !== 1'b0 || strip0 !== 1'b0) begin
            errors++;
            $display("FAIL idle after reset: busy=%b strip=%b want 0 0", busy0, strip0);
        end
    endtask

    task automatic test_full_frame();
        int h0, p0, f0;
        sel = 1'b0; valid = 1'b1; data = 24'hA5A5A5;
        h0 = hs_cnt; p0 = pd_cnt; f0 = fd_cnt;
        begin_frame("frame");
        check_pixel(24'hA5A5A5, -1, "frame px0");
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame gap ready: got %b want 1", m_ready);
        end
        data = 24'h3C00F1;
        tick();
        check_pixel(24'h3C00F1, -1, "frame px1");
        run_latch(-1, "frame");
        repeat (2) tick();
        checks++;
        if (hs_cnt - h0 != 2 || pd_cnt - p0 != 2 || fd_cnt - f0 != 1) begin
            errors++;
            $display("FAIL frame counts: hs=%0d pd=%0d fd=%0d want 2 2 1", hs_cnt - h0, pd_cnt - p0, fd_cnt - f0);
        end
    endtask

    task automatic test_stall();
        int h0, bad;
        bad = 0;
        valid = 1'b1; data = 24'hA5A5A5;
        begin_frame("stall");
        check_pixel(24'hA5A5A5, -1, "stall px0");
        valid = 1'b0; data = 24'h0F0F0F;
        h0 = hs_cnt;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_strip !== 1'b0 || m_ready !== 1'b1 || m_pd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || hs_cnt != h0) begin
            errors++;
            $display("FAIL stall: bad cycles=%0d handshakes=%0d want 0 0", bad, hs_cnt - h0);
        end
        valid = 1'b1;
        tick();
        check_pixel(24'h0F0F0F, -1, "stall px1");
        run_latch(-1, "stall");
    endtask

    task automatic test_reset_mid();
        int p0, h0;
        valid = 1'b1; data = 24'hA5A5A5;
        begin_frame("rstmid");
        repeat (78) tick();
        checks++;
        if (m_strip !== 1'b1) begin
            errors++;
            $display("FAIL rstmid bit10 high: got %b want 1", m_strip);
        end
        p0 = pd_cnt;
        rst_n = 1'b0;
        tick();
        checks++;
        if (m_strip !== 1'b0 || m_busy !== 1'b0 || m_pd !== 1'b0) begin
            errors++;
            $display("FAIL rstmid abort: strip=%b busy=%b pd=%b want 0 0 0", m_strip, m_busy, m_pd);
        end
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (pd_cnt != p0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid no strobe: pd=%0d busy=%b want 0 0", pd_cnt - p0, m_busy);
        end
        h0 = hs_cnt;
        begin_frame("rstmid new");
        check_pixel(24'hA5A5A5, -1, "rstmid px0");
        data = 24'h5A5A5A;
        tick();
        check_pixel(24'h5A5A5A, -1, "rstmid px1");
        run_latch(-1, "rstmid");
        checks++;
        if (hs_cnt - h0 != 2) begin
            errors++;
            $display("FAIL rstmid handshakes: got %0d want 2", hs_cnt - h0);
        end
    endtask

    task automatic test_start_busy();
        int f0, bad;
        bad = 0;
        valid = 1'b1; data = 24'hC33C99;
        f0 = fd_cnt;
        begin_frame("busy");
        check_pixel(24'hC33C99, 4, "busy px0");
        data = 24'h81FF00;
        tick();
        check_pixel(24'h81FF00, -1, "busy px1");
        run_latch(5, "busy");
        for (int i = 0; i < 5; i++) begin
            if (m_busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || fd_cnt - f0 != 1) begin
            errors++;
            $display("FAIL busy ignore: busy cycles=%0d fd=%0d want 0 1", bad, fd_cnt - f0);
        end
        data = 24'h000001;
        begin_frame("busy2");
        check_pixel(24'h000001, -1, "busy2 px0");
        tick();
        check_pixel(24'h000001, -1, "busy2 px1");
        run_latch(TR, "busy2 start at done");
        set_start(1'b1);
        tick();
        set_start(1'b0);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL start after done: busy=%b want 1", m_busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_edges();
        int h0, p0;
        sel = 1'b0; valid = 1'b1; data = 24'h000000;
        begin_frame("edge");
        check_pixel(24'h000000, -1, "edge zeros");
        data = 24'hFFFFFF;
        tick();
        check_pixel(24'hFFFFFF, -1, "edge ones");
        run_latch(-1, "edge");
        sel = 1'b1; data = 24'h800001;
        repeat (2) tick();
        h0 = hs_cnt; p0 = pd_cnt;
        begin_frame("single");
        check_pixel(24'h800001, -1, "single px0");
        run_latch(-1, "single");
        repeat (2) tick();
        checks++;
        if (hs_cnt - h0 != 1 || pd_cnt - p0 != 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL single counts: hs=%0d pd=%0d busy0=%b want 1 1 0", hs_cnt - h0, pd_cnt - p0, busy0);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_reset_mid();
        test_start_busy();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ws2812_tx.md
Name: ws2812_tx

Overview:
- Single-wire serializer for WS2812-class addressable LED strips.
- Pulls 24-bit GRB pixel words from the frame-buffer read path over a valid/ready handshake.
- Emits one pulse-width-coded bit stream per frame, followed by the latch (reset) gap.
- Produces a one-cycle pixel_done_out strobe per transmitted pixel. This strobe drives the downstream pixel-index event counter that addresses the frame buffer.

Parameters:
- T0H_CYCLES, 40, strip_out high cycles for a 0 bit.
- T0L_CYCLES, 85, strip_out low cycles for a 0 bit.
- T1H_CYCLES, 80, strip_out high cycles for a 1 bit.
- T1L_CYCLES, 45, strip_out low cycles for a 1 bit.
- TRESET_CYCLES, 8000, strip_out low cycles for the latch gap after the last pixel.
- NUM_PIXELS, 64, pixels per frame. Must be ≥1; all timing parameters must be ≥1.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, reset; synchronous, active-low.
- start_in, input, 1, one-cycle frame start request.
- pixel_data_in, input, 24, GRB pixel word; bit 23 is transmitted first.
- pixel_valid_in, input, 1, pixel_data_in valid.
- pixel_ready_out, output, 1, block accepts a pixel this cycle.
- pixel_done_out, output, 1, one-cycle strobe when a pixel's last bit completes.
- frame_done_out, output, 1, one-cycle strobe when the latch gap ends.
- busy_out, output, 1, frame in progress.
- strip_out, output, 1, registered serial line to the LED strip.

Behaviour:
- Reset (rst_n_in low at a clock edge):
  - All outputs go to 0.
  - State goes to IDLE; internal counters and the shift register clear.
  - Applies mid-frame: strip_out drops low on that same edge. No strobe is emitted for the aborted pixel.
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE:
  - strip_out=0, busy_out=0.
  - start_in=1 moves to LOAD; busy_out=1 from the next cycle.
- LOAD:
  - pixel_ready_out=1. It is combinational from state and is high only in LOAD.
  - On pixel_valid_in & pixel_ready_out: latch pixel_data_in into a 24-bit shift register, set bit index to 23, go to HIGH.
  - Without valid, stay in LOAD with strip_out=0, indefinitely. Upstream must keep stalls short enough not to trigger a strip latch; no timeout.
- HIGH:
  - strip_out=1 for exactly T1H_CYCLES if the current bit is 1, else T0H_CYCLES.
  - The first high cycle is the cycle after the handshake or after the previous LOW.
  - Then go to LOW.
- LOW:
  - strip_out=0 for exactly T1L_CYCLES or T0L_CYCLES.
  - If bits remain: shift left, decrement the index, go to HIGH.
  - After bit 0: pixel_done_out=1 for one cycle, coincident with the transition. Increment the pixel count.
  - If pixel count was NUM_PIXELS-1, go to LATCH, else go to LOAD.
- Inter-pixel gap: the low phase of bit 0 of a non-final pixel is extended by the LOAD cycles. With valid held high, exactly 1 extra cycle.
- LATCH:
  - strip_out=0 for TRESET_CYCLES.
  - Then frame_done_out=1 for one cycle, pixel count clears, go to IDLE (busy_out=0 next cycle).
- start_in while busy_out=1 is ignored; no queuing.
- start_in on the same cycle as frame_done_out is ignored. It is accepted from the following cycle.
- pixel_valid_in outside LOAD is ignored; data is not consumed.
- Timing counter:
  - Width is $clog2 of the largest timing parameter + 1.
  - Loads (duration-1) on entry to each phase and counts down to 0; no wrap.
- Pixel counter: width $clog2(NUM_PIXELS+1). It never exceeds NUM_PIXELS-1 during a frame.

Test Plan:
1. Timing: params T0H=2, T0L=4, T1H=4, T1L=2, TRESET=10, NUM_PIXELS=2. Start, then present 24'hA5A5A5 with valid held high → strip_out pattern per bit:
   - 1 → 4 high, 2 low.
   - 0 → 2 high, 4 low.
   - MSB first.
   - pixel_done_out pulses 144 cycles after the first high cycle.
2. Full frame, same params, valid held high → exactly 2 handshakes and 2 pixel_done_out strobes. Second pixel starts 1 cycle after the first strobe. strip_out is low for 10 cycles, then frame_done_out pulses once. busy_out falls the next cycle.
3. Stall: hold pixel_valid_in low for 50 cycles in LOAD between pixels → strip_out stays 0 throughout, pixel_ready_out stays 1, no strobe. Transmission resumes the cycle after valid rises.
4. Reset mid-operation: rst_n_in low during HIGH of bit 10 of pixel 0 → strip_out=0 and busy_out=0 next edge, no pixel_done_out. A new start sends a full frame from pixel 0.
5. Start while busy: pulse start_in during LOW and during LATCH → no effect; exactly one frame_done_out.
6. Edge values: 24'h000000 and 24'hFFFFFF → all bits 2H/4L, and all bits 4H/2L respectively. NUM_PIXELS=1 → a single strobe, then LATCH.
